// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with read-modify-write for sub-word stores
//
// Purpose: accepts one decoded load/store per transaction, checks alignment and
// range, drives the word-wide data memory and returns extended load data.
// SB/SH become a read in IDLE followed by a whole-word write in MERGE.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/op/addr/wdata  request from the pipeline
//   busy                  stall while the MERGE write is pending
//   done, addr_err        completion / error pulses (registered)
//   ld_data               extended load result, held until the next load
//   dm_ena/wena/w_cs/r_cs/addr/wdata  data-memory strobes (combinational)
//   dm_rdata              data-memory combinational read data

module mem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        addr_err,
    output logic        dm_ena,
    output logic        dm_wena,
    output logic        dm_w_cs,
    output logic        dm_r_cs,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    // One past the last valid byte; 33 bits so a top-of-space window cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t      state_q;
    logic        done_q;
    logic        addr_err_q;
    logic [31:0] ld_data_q;
    logic [31:0] merge_q;
    logic [31:0] addr_q;

    logic        accept;
    logic        is_load;
    logic        is_sw;
    logic        misalign;
    logic        out_of_range;
    logic        err;
    logic [31:0] word_addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data_d;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merge_d;

    assign accept    = (state_q == IDLE) && req_valid;
    assign is_load   = (req_op <= OP_LHU);
    assign is_sw     = (req_op == OP_SW);
    assign word_addr = {req_addr[31:2], 2'b00};

    always_comb begin
        misalign = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misalign = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            default:              misalign = 1'b0;
        endcase
        out_of_range = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= END_ADDR);
        err          = misalign || out_of_range;
    end

    // Load lane selection and extension.
    always_comb begin
        byte_sel  = 8'(dm_rdata >> {req_addr[1:0], 3'b000});
        half_sel  = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ld_data_d = dm_rdata;
        case (req_op)
            OP_LB:   ld_data_d = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data_d = {24'h0, byte_sel};
            OP_LH:   ld_data_d = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_data_d = {16'h0, half_sel};
            default: ld_data_d = dm_rdata;
        endcase
    end

    // Merge the store lane into the word read in IDLE; the result is written in MERGE.
    always_comb begin
        if (req_op == OP_SH) begin
            lane_mask = 32'h0000FFFF << {req_addr[1], 4'b0000};
            lane_data = {16'h0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
        end else begin
            lane_mask = 32'h000000FF << {req_addr[1:0], 3'b000};
            lane_data = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
        end
        merge_d = (dm_rdata & ~lane_mask) | (lane_data & lane_mask);
    end

    // Data-memory strobes; all zero unless an access happens this cycle.
    always_comb begin
        dm_ena   = 1'b0;
        dm_wena  = 1'b0;
        dm_w_cs  = 1'b0;
        dm_r_cs  = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        if (state_q == MERGE) begin
            dm_ena   = 1'b1;
            dm_wena  = 1'b1;
            dm_w_cs  = 1'b1;
            dm_addr  = addr_q;
            dm_wdata = merge_q;
        end else if (accept && !err) begin
            dm_ena  = 1'b1;
            dm_addr = word_addr;
            if (is_sw) begin
                dm_wena  = 1'b1;
                dm_w_cs  = 1'b1;
                dm_wdata = req_wdata;
            end else begin
                dm_r_cs = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            ld_data_q  <= 32'h0;
            merge_q    <= 32'h0;
            addr_q     <= 32'h0;
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (err) begin
                            done_q     <= 1'b1;
                            addr_err_q <= 1'b1;
                        end else if (is_load) begin
                            ld_data_q <= ld_data_d;
                            done_q    <= 1'b1;
                        end else if (is_sw) begin
                            done_q <= 1'b1;
                        end else begin
                            merge_q <= merge_d;
                            addr_q  <= word_addr;
                            state_q <= MERGE;
                        end
                    end
                end
                MERGE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == MERGE);
    assign done     = done_q;
    assign addr_err = addr_err_q;
    assign ld_data  = ld_data_q;

endmodule
